// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t    - scan FSM states (OFF, SHOW, BLANK)
//   seg7_t     - 7-bit segment vector, bit0=A ... bit6=G, active high
//   SEG7_TABLE - hex nibble to segment pattern lookup
package seg7_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    typedef logic [6:0] seg7_t;

    // Patterns written G..A (MSB first).
    localparam seg7_t SEG7_TABLE [0:15] = '{
        7'b0111111,     // 0
        7'b0000110,     // 1
        7'b1011011,     // 2
        7'b1001111,     // 3
        7'b1100110,     // 4
        7'b1101101,     // 5
        7'b1111101,     // 6
        7'b0000111,     // 7
        7'b1111111,     // 8
        7'b1101111,     // 9
        7'b1110111,     // A
        7'b1111100,     // b
        7'b0111001,     // C
        7'b1011110,     // d
        7'b1111001,     // E
        7'b1110001      // F
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to 7-segment pattern lookup.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
//
// Ports:
//   nibble - 4-bit hex value to display
//   seg    - active-high segment pattern, bit0=A ... bit6=G
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG common-cathode style 7-segment digits.
// Latency: outputs registered; a new display value appears at the next frame boundary (immediately when OFF).
// Backpressure: load_ready drops once a value is pending while scanning and returns when the frame wraps.
//
// Ports:
//   clk, rst_n           - single clock, asynchronous active-low reset
//   enable               - scanning runs while high; low forces all outputs off
//   load_valid/ready     - valid/ready handshake for a new display value
//   load_data, load_dp   - hex nibbles (nibble 0 = rightmost digit) and decimal points
//   seg, dp, an          - segment, decimal point and one-hot digit enables (active high)
//   frame_done           - one-cycle pulse when the scan wraps from the last digit to digit 0
//
// Build option: define SEG7_LZS_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*NDIG-1:0]   load_data,
    input  logic [NDIG-1:0]     load_dp,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [NDIG-1:0]     an,
    output logic                frame_done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    // One slot is TICK_DIV cycles: cnt runs 0..SHOW_LAST in SHOW, then on
    // through SLOT_LAST in BLANK, so it never exceeds TICK_DIV-1.
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(TICK_DIV - BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [IDX_W-1:0]       idx, idx_d;

    logic [4*NDIG-1:0]      disp, disp_d;
    logic [NDIG-1:0]        disp_dp, disp_dp_d;
    logic [4*NDIG-1:0]      pend, pend_d;
    logic [NDIG-1:0]        pend_dp, pend_dp_d;
    logic                   pend_full, pend_full_d;

    logic [6:0]             seg_d;
    logic                   dp_d;
    logic [NDIG-1:0]        an_d;
    logic                   frame_done_d;

    logic                   wrap;
    logic                   xfer;
    logic [3:0]             nib;
    logic [6:0]             seg_dec;
    logic                   blank_digit;

    // The only thing that blocks a transfer is an occupied pending slot,
    // and that slot is always empty while OFF.
    assign load_ready = ~pend_full;
    assign xfer       = load_valid & load_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        wrap    = 1'b0;

        if (!enable) begin
            state_d = OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                SHOW: begin
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == SHOW_LAST) begin
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    if (cnt == SLOT_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        if (idx == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display / pending registers
    // ------------------------------------------------------------------
    always_comb begin
        disp_d      = disp;
        disp_dp_d   = disp_dp;
        pend_d      = pend;
        pend_dp_d   = pend_dp;
        pend_full_d = pend_full;

        if (state == OFF || !enable) begin
            // Not scanning (or about to stop): nothing can tear, so a
            // held value is flushed and a new one goes straight to disp.
            if (pend_full) begin
                disp_d    = pend;
                disp_dp_d = pend_dp;
            end
            if (xfer) begin
                disp_d    = load_data;
                disp_dp_d = load_dp;
            end
            pend_full_d = 1'b0;
        end else begin
            // Scanning: new values only take effect at a frame boundary.
            if (wrap && pend_full) begin
                disp_d      = pend;
                disp_dp_d   = pend_dp;
                pend_full_d = 1'b0;
            end
            if (xfer) begin
                pend_d      = load_data;
                pend_dp_d   = load_dp;
                pend_full_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output generation, computed from next state so the registered
    // outputs change on the same edge as the state.
    // ------------------------------------------------------------------
    assign nib = disp_d[4*int'(idx_d) +: 4];

    seg7_decode u_decode (
        .nibble (nib),
        .seg    (seg_dec)
    );

`ifdef SEG7_LZS_EN
    logic [IDX_W-1:0] msnz;

    // Highest digit holding a nonzero nibble; digits above it are blanked.
    // With an all-zero value msnz stays 0, so digit 0 still shows "0".
    always_comb begin
        msnz = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (disp_d[4*i +: 4] != 4'h0) begin
                msnz = IDX_W'(i);
            end
        end
        blank_digit = (idx_d > msnz);
    end
`else
    assign blank_digit = 1'b0;
`endif

    always_comb begin
        seg_d        = '0;
        dp_d         = 1'b0;
        an_d         = '0;
        frame_done_d = wrap;

        if (state_d == SHOW) begin
            an_d  = NDIG'(1) << idx_d;
            seg_d = blank_digit ? 7'd0 : seg_dec;
            dp_d  = disp_dp_d[idx_d];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            disp_dp    <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_full  <= 1'b0;
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            disp       <= disp_d;
            disp_dp    <= disp_dp_d;
            pend       <= pend_d;
            pend_dp    <= pend_dp_d;
            pend_full  <= pend_full_d;
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

    localparam int NDIG      = 4;
    localparam int TICK_DIV  = 10;
    localparam int BLANK_CYC = 2;
    localparam int SHOW_CYC  = TICK_DIV - BLANK_CYC;

`ifdef SEG7_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               clk_run = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               load_valid;
    logic               load_ready;
    logic [4*NDIG-1:0]  load_data;
    logic [NDIG-1:0]    load_dp;
    logic [6:0]         seg;
    logic               dp;
    logic [NDIG-1:0]    an;
    logic               frame_done;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    seg7_scan_ctrl #(
        .NDIG      (NDIG),
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    // Decode vectors: nibble, decimal point to load with it, expected segments (G..A).
    typedef struct {
        logic [3:0] nib;
        logic       dpv;
        logic [6:0] seg;
    } vec_t;
    vec_t vt [16];

    // Expected per-cycle output; lr: 0/1 expected load_ready, 2 = not checked.
    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic [1:0] lr;
    } exp_t;
    exp_t sb [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push1(input logic [3:0] a, input logic [6:0] s, input logic d,
                         input logic f, input logic [1:0] r);
        exp_t e;
        e.an = a; e.seg = s; e.dp = d; e.fd = f; e.lr = r;
        sb.push_back(e);
    endtask

    // Queue the 40 expected cycles of one scan frame.
    task automatic push_frame(input logic [15:0] data, input logic [3:0] dpv,
                              input logic fd_first, input logic [1:0] lr_first,
                              input logic [1:0] lr_rest);
        int         msnz;
        logic [3:0] n;
        logic [6:0] s;
        msnz = 0;
        for (int i = 0; i < NDIG; i++)
            if (data[4*i +: 4] != 4'h0) msnz = i;
        for (int d = 0; d < NDIG; d++) begin
            n = data[4*d +: 4];
            s = (LZS && d > msnz) ? 7'd0 : vt[n].seg;
            for (int c = 0; c < TICK_DIV; c++) begin
                if (c < SHOW_CYC)
                    push1(4'(1 << d), s, dpv[d], (d == 0 && c == 0) ? fd_first : 1'b0,
                          (d == 0 && c == 0) ? lr_first : lr_rest);
                else
                    push1(4'd0, 7'd0, 1'b0, 1'b0, lr_rest);
            end
        end
    endtask

    // Pop and compare one expected entry per cycle, sampled at negedge.
    task automatic run(input int n, input string name);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s #%0d: scoreboard empty", name, k);
            end else begin
                e = sb.pop_front();
                if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd ||
                    (e.lr != 2'd2 && load_ready !== e.lr[0])) begin
                    n_fail++;
                    $display("FAIL %s #%0d: got an=%b seg=%b dp=%b fd=%b rdy=%b, want an=%b seg=%b dp=%b fd=%b rdy=%0d",
                             name, k, an, seg, dp, frame_done, load_ready,
                             e.an, e.seg, e.dp, e.fd, e.lr);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[ 0] = '{4'h0, 1'b0, 7'b0111111};
        vt[ 1] = '{4'h1, 1'b1, 7'b0000110};
        vt[ 2] = '{4'h2, 1'b0, 7'b1011011};
        vt[ 3] = '{4'h3, 1'b1, 7'b1001111};
        vt[ 4] = '{4'h4, 1'b0, 7'b1100110};
        vt[ 5] = '{4'h5, 1'b1, 7'b1101101};
        vt[ 6] = '{4'h6, 1'b0, 7'b1111101};
        vt[ 7] = '{4'h7, 1'b1, 7'b0000111};
        vt[ 8] = '{4'h8, 1'b0, 7'b1111111};
        vt[ 9] = '{4'h9, 1'b1, 7'b1101111};
        vt[10] = '{4'hA, 1'b0, 7'b1110111};
        vt[11] = '{4'hB, 1'b1, 7'b1111100};
        vt[12] = '{4'hC, 1'b0, 7'b0111001};
        vt[13] = '{4'hD, 1'b1, 7'b1011110};
        vt[14] = '{4'hE, 1'b0, 7'b1111001};
        vt[15] = '{4'hF, 1'b1, 7'b1110001};

        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_dp    = '0;
        rst_n      = 1'b0;

        // Reset with the clock stopped.
        #3;
        chk("rst_an",   32'(an),         32'h0);
        chk("rst_seg",  32'(seg),        32'h0);
        chk("rst_dp",   32'(dp),         32'h0);
        chk("rst_rdy",  32'(load_ready), 32'h1);
        chk("rst_fd",   32'(frame_done), 32'h0);

        clk_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_an", 32'(an), 32'h0);

        // Load 12AF while OFF, then scan one full frame.
        load_valid = 1'b1;
        load_data  = 16'h12AF;
        load_dp    = 4'b0000;
        @(negedge clk);
        chk("off_rdy", 32'(load_ready), 32'h1);
        load_valid = 1'b0;
        enable     = 1'b1;
        push_frame(16'h12AF, 4'b0000, 1'b0, 2'd1, 2'd1);
        push_frame(16'h12AF, 4'b0000, 1'b1, 2'd1, 2'd0);
        run(41, "frame1");

        // Mid-frame load of 0000: held until the wrap.
        load_valid = 1'b1;
        load_data  = 16'h0000;
        load_dp    = 4'b0000;
        run(1, "pend_accept");
        load_valid = 1'b0;
        run(38, "frame2");

        // New frame shows 0000; drop enable during SHOW of digit 2.
        push_frame(16'h0000, 4'b0000, 1'b1, 2'd2, 2'd1);
        run(2 * TICK_DIV + 3, "frame3");
        enable = 1'b0;
        sb.delete();
        push1(4'd0, 7'd0, 1'b0, 1'b0, 2'd1);
        run(1, "disable");
        enable = 1'b1;
        push1(4'b0001, vt[0].seg, 1'b0, 1'b0, 2'd1);
        run(1, "reenable");

        // Asynchronous reset in the middle of SHOW.
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_an", 32'(an), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an",  32'(an),         32'h0);
        chk("async_seg", 32'(seg),        32'h0);
        chk("async_rdy", 32'(load_ready), 32'h1);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_an", 32'(an), 32'h0);
        enable = 1'b1;
        @(negedge clk);
        chk("post_rst_show_an",  32'(an),  32'h1);
        chk("post_rst_show_seg", 32'(seg), 32'(vt[0].seg));
        enable = 1'b0;
        @(negedge clk);

        // Leading-zero pattern 0030 with a dp on the top digit.
        load_valid = 1'b1;
        load_data  = 16'h0030;
        load_dp    = 4'b1000;
        @(negedge clk);
        load_valid = 1'b0;
        enable     = 1'b1;
        push_frame(16'h0030, 4'b1000, 1'b0, 2'd1, 2'd1);
        run(NDIG * TICK_DIV, "lzs_frame");
        enable = 1'b0;
        sb.delete();
        @(negedge clk);

        // Decode table: each nibble on every digit, digit 0 checked on entry to SHOW.
        for (int v = 0; v < 16; v++) begin
            load_valid = 1'b1;
            load_data  = {NDIG{vt[v].nib}};
            load_dp    = {NDIG{vt[v].dpv}};
            @(negedge clk);
            load_valid = 1'b0;
            enable     = 1'b1;
            push1(4'b0001, vt[v].seg, vt[v].dpv, 1'b0, 2'd1);
            run(1, "decode");
            enable = 1'b0;
            push1(4'd0, 7'd0, 1'b0, 1'b0, 2'd1);
            run(1, "decode_off");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
